// File: rtl/input_debouncer_pkg.sv
// Shared types and sizing helpers for the input debouncer and its sub-blocks.
package debounce_pkg;

   typedef enum logic [1:0] {
      IDLE_LOW   = 2'd0,
      CHECK_HIGH = 2'd1,
      IDLE_HIGH  = 2'd2,
      CHECK_LOW  = 2'd3
   } state_t;

   // Run counter must reach stable_cycles without wrapping.
   function automatic int unsigned cnt_width(input int unsigned stable_cycles);
      return $clog2(stable_cycles + 1);
   endfunction

endpackage

// File: rtl/input_debouncer_sync_chain.sv
// Plain flop chain bringing an asynchronous bit into the clk domain; reset to 0.
module sync_chain #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronizes a raw input and commits level changes only after a stable run of samples.
module input_debouncer
   import debounce_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STABLE_CYCLES = 16,
   parameter int unsigned GLITCH_CNT_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    a_async,
   input  logic                    clr_glitch,
   output logic                    a_clean,
   output logic                    rise,
   output logic                    fall,
   output logic                    busy,
   output logic [GLITCH_CNT_W-1:0] glitch_count
);

   localparam int unsigned CNT_W = cnt_width(STABLE_CYCLES);

   logic                    a_s;
   state_t                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic                    a_clean_q;
   logic                    rise_q;
   logic                    fall_q;
   logic [GLITCH_CNT_W-1:0] glitch_q;
   logic                    abort_c;
   logic                    last_c;

   sync_chain #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d_i(a_async),
      .q_o(a_s)
   );

   // A candidate is dropped as soon as a sample matches the committed level again.
   assign abort_c = ((state_q == CHECK_HIGH) && !a_s) || ((state_q == CHECK_LOW) && a_s);
   assign last_c  = (cnt_q == CNT_W'(STABLE_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE_LOW;
         cnt_q     <= '0;
         a_clean_q <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
         glitch_q  <= '0;
      end else begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;

         if (clr_glitch) begin
            glitch_q <= '0;
         end else if (abort_c && (glitch_q != '1)) begin
            glitch_q <= glitch_q + GLITCH_CNT_W'(1);
         end

         case (state_q)
            IDLE_LOW: begin
               if (a_s) begin
                  if (STABLE_CYCLES == 1) begin
                     state_q   <= IDLE_HIGH;
                     cnt_q     <= '0;
                     a_clean_q <= 1'b1;
                     rise_q    <= 1'b1;
                  end else begin
                     state_q <= CHECK_HIGH;
                     cnt_q   <= CNT_W'(1);
                  end
               end
            end
            CHECK_HIGH: begin
               if (!a_s) begin
                  state_q <= IDLE_LOW;
                  cnt_q   <= '0;
               end else if (last_c) begin
                  state_q   <= IDLE_HIGH;
                  cnt_q     <= '0;
                  a_clean_q <= 1'b1;
                  rise_q    <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            IDLE_HIGH: begin
               if (!a_s) begin
                  if (STABLE_CYCLES == 1) begin
                     state_q   <= IDLE_LOW;
                     cnt_q     <= '0;
                     a_clean_q <= 1'b0;
                     fall_q    <= 1'b1;
                  end else begin
                     state_q <= CHECK_LOW;
                     cnt_q   <= CNT_W'(1);
                  end
               end
            end
            CHECK_LOW: begin
               if (a_s) begin
                  state_q <= IDLE_HIGH;
                  cnt_q   <= '0;
               end else if (last_c) begin
                  state_q   <= IDLE_LOW;
                  cnt_q     <= '0;
                  a_clean_q <= 1'b0;
                  fall_q    <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE_LOW;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign a_clean      = a_clean_q;
   assign rise         = rise_q;
   assign fall         = fall_q;
   assign busy         = (state_q == CHECK_HIGH) || (state_q == CHECK_LOW);
   assign glitch_count = glitch_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Random and directed stimulus against a run-length reference model of the debouncer.
module tb_input_debouncer;

   localparam int unsigned SYNC   = 2;
   localparam int unsigned STABLE = 16;
   localparam int unsigned GW     = 8;
   localparam int          GMAX   = (1 << GW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          a_async = 1'b0;
   logic          clr_glitch = 1'b0;
   logic          a_clean;
   logic          rise;
   logic          fall;
   logic          busy;
   logic [GW-1:0] glitch_count;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   input_debouncer #(
      .SYNC_STAGES(SYNC),
      .STABLE_CYCLES(STABLE),
      .GLITCH_CNT_W(GW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .a_async(a_async),
      .clr_glitch(clr_glitch),
      .a_clean(a_clean),
      .rise(rise),
      .fall(fall),
      .busy(busy),
      .glitch_count(glitch_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a delay line for the synchronizer, then a run length of samples
   // that disagree with the committed level.
   bit sq[$];
   bit m_s;
   bit m_clean, m_rise, m_fall;
   int m_run, m_glitch;

   always @(posedge clk) begin
      if (rst) begin
         sq = {};
         for (int i = 0; i < SYNC; i++) sq.push_back(1'b0);
         m_clean = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
         m_run = 0; m_glitch = 0;
      end else begin
         m_s = sq.pop_front();
         sq.push_back(a_async);
         m_rise = 1'b0;
         m_fall = 1'b0;
         if (m_s != m_clean) begin
            m_run++;
            if (m_run == STABLE) begin
               m_clean = m_s;
               m_rise  = m_s;
               m_fall  = !m_s;
               m_run   = 0;
            end
         end else if (m_run > 0) begin
            m_run = 0;
            if (m_glitch < GMAX) m_glitch++;
         end
         if (clr_glitch) m_glitch = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_a_clean", int'(a_clean), int'(m_clean));
         check("m_rise", int'(rise), int'(m_rise));
         check("m_fall", int'(fall), int'(m_fall));
         check("m_busy", int'(busy), int'(m_run > 0));
         check("m_glitch", int'(glitch_count), m_glitch);
         check("m_rise_fall_excl", int'(rise & fall), 0);
      end
   end

   // Edges from the current negedge until a_clean reaches lvl; also tallies strobes and busy.
   task automatic measure(input bit lvl, output int lat, output int rises,
                          output int falls, output int busys);
      lat = -1; rises = 0; falls = 0; busys = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (rise) rises++;
         if (fall) falls++;
         if (busy) busys++;
         if (a_clean == lvl) begin
            lat = i + 1;
            break;
         end
      end
      repeat (5) begin
         @(posedge clk); #1;
         if (rise) rises++;
         if (fall) falls++;
      end
      @(negedge clk);
   endtask

   task automatic glitch_pulse(input int hi);
      a_async = 1'b1;
      repeat (hi) @(negedge clk);
      a_async = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   int lat, rises, falls, busys;

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_a_clean", int'(a_clean), 0);
      check("rst_rise", int'(rise), 0);
      check("rst_fall", int'(fall), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_glitch", int'(glitch_count), 0);
      chk_en = 1'b1;
      rst = 1'b0;
      repeat (4) @(negedge clk);

      a_async = 1'b1;
      measure(1'b1, lat, rises, falls, busys);
      check("rise_latency", lat, 18);
      check("rise_count", rises, 1);
      check("rise_busy_cycles", busys, 15);
      check("rise_glitch", int'(glitch_count), 0);
      repeat (3) @(negedge clk);

      a_async = 1'b0;
      measure(1'b0, lat, rises, falls, busys);
      check("fall_latency", lat, 18);
      check("fall_count", falls, 1);
      check("fall_no_rise", rises, 0);
      repeat (3) @(negedge clk);

      glitch_pulse(5);
      check("glitch_a_clean", int'(a_clean), 0);
      check("glitch_one", int'(glitch_count), 1);
      check("glitch_busy", int'(busy), 0);

      for (int i = 0; i < 300; i++) glitch_pulse(5);
      check("glitch_sat", int'(glitch_count), 255);
      clr_glitch = 1'b1;
      @(negedge clk);
      clr_glitch = 1'b0;
      check("glitch_clr", int'(glitch_count), 0);
      glitch_pulse(5);
      check("glitch_after_clr", int'(glitch_count), 1);

      // Clear lands on the same edge as the abort.
      a_async = 1'b1;
      repeat (5) @(negedge clk);
      a_async = 1'b0;
      @(negedge clk);
      @(negedge clk);
      clr_glitch = 1'b1;
      @(negedge clk);
      clr_glitch = 1'b0;
      check("clr_vs_abort", int'(glitch_count), 0);
      check("clr_vs_abort_busy", int'(busy), 0);
      repeat (4) @(negedge clk);

      // Reset during sample 8 of a rising qualification.
      a_async = 1'b1;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_a_clean", int'(a_clean), 0);
      check("mid_rst_rise", int'(rise), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_glitch", int'(glitch_count), 0);
      measure(1'b1, lat, rises, falls, busys);
      check("post_rst_latency", lat, 18);
      check("post_rst_rise", rises, 1);

      for (int n = 0; n < 400; n++) begin
         int len;
         a_async = 1'($urandom_range(0, 1));
         len = int'($urandom_range(1, 24));
         for (int k = 0; k < len; k++) begin
            clr_glitch = ($urandom_range(0, 49) == 0);
            rst        = ($urandom_range(0, 599) == 0);
            @(negedge clk);
         end
      end
      clr_glitch = 1'b0;
      rst = 1'b0;
      repeat (30) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
